// File: rtl/upsp_pkg.sv
// Shared types and width helpers for the upsp write-arbiter slice.
package upsp_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int beat_w(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n + 1) : 1;
  endfunction

  localparam int GRANT_W_DEF = idx_w(4);
  localparam int BEAT_W_DEF  = beat_w(4);
  localparam int FRAME_W_DEF = cnt_w(8294400);

endpackage

// File: rtl/upsp_wr_arbiter_rr_pick.sv
// Rotating-priority selector: first set request at or above ptr, with wrap.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  int         j;
  logic [W-1:0] jj;

  // Walk offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = W'(j);
      if (req[jj]) begin
        idx = jj;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/upsp_wr_arbiter.sv
// Round-robin write arbiter merging N_REQ beat streams into one.
// UPSP_ARB_BURST_LOCK_EN holds each grant for BURST_LEN beats.
module upsp_wr_arbiter
  import upsp_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_WIDTH  = 96,
  parameter int BURST_LEN   = 4,
  parameter int FRAME_BEATS = 8294400
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_wvalid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            req_wready,
  output logic                        ac_wvalid,
  output logic [DATA_WIDTH-1:0]       ac_wdata,
  input  logic                        ac_wready,
  output logic [idx_w(N_REQ)-1:0]     grant_id,
  input  logic                        frame_start,
  output logic                        frame_done
);

  localparam int GW = idx_w(N_REQ);
  localparam int BW = beat_w(BURST_LEN);
  localparam int FW = cnt_w(FRAME_BEATS);
`ifdef UPSP_ARB_BURST_LOCK_EN
  localparam int EFF_LEN = BURST_LEN;
`else
  localparam int EFF_LEN = 1;
`endif

  arb_state_t     state;
  logic [GW-1:0]  grant;
  logic [GW-1:0]  rr_ptr;
  logic [GW-1:0]  nxt_ptr;
  logic [GW-1:0]  pick_idx;
  logic           pick_any;
  logic [BW-1:0]  beat_cnt;
  logic [FW-1:0]  frame_cnt;
  logic [FW-1:0]  frame_nxt;
  logic           xfer;
  logic           last;

  rr_pick #(
    .N (N_REQ),
    .W (GW)
  ) u_pick (
    .req (req_wvalid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    ac_wvalid  = 1'b0;
    ac_wdata   = '0;
    req_wready = '0;
    if (state == ST_BURST) begin
      ac_wvalid         = req_wvalid[grant];
      ac_wdata          = req_wdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
      req_wready[grant] = ac_wready;
    end
  end

  assign xfer     = ac_wvalid & ac_wready;
  assign last     = xfer && (beat_cnt == BW'(EFF_LEN - 1));
  assign nxt_ptr  = (grant == GW'(N_REQ - 1)) ? '0 : grant + 1'b1;
  assign grant_id = grant;

  // A coincident frame_start restarts the count with this beat as beat 1.
  assign frame_nxt  = frame_start ? FW'(1) : frame_cnt + 1'b1;
  assign frame_done = xfer && (frame_nxt == FW'(FRAME_BEATS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          beat_cnt <= '0;
          if (pick_any) begin
            grant <= pick_idx;
            state <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (last) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            rr_ptr   <= nxt_ptr;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (xfer) begin
      frame_cnt <= frame_done ? '0 : frame_nxt;
    end else if (frame_start) begin
      frame_cnt <= '0;
    end
  end

endmodule
